// File: rtl/cpu_pkg.sv
// Shared definitions for the fetch/decode front end: opcode values, FSM state
// encoding and instruction-byte field positions.
package cpu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_MOVI = 3'b100,
    OP_NOP  = 3'b111
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_IMM   = 2'd1,
    S_HOLD  = 2'd2,
    S_HALT  = 2'd3
  } state_e;

  localparam int OP_MSB  = 7;
  localparam int OP_LSB  = 5;
  localparam int RD_MSB  = 4;
  localparam int RD_LSB  = 3;
  localparam int RS_MSB  = 2;
  localparam int RS_LSB  = 1;
  localparam int RSV_BIT = 0;

  localparam logic [7:0] HALT_BYTE = 8'hFF;

endpackage

// File: rtl/fetch_decode_if.sv
// Bundle of the instruction-memory, decode-handshake and redirect signals of
// the fetch/decode stage; master is the stage itself, slave is its environment.
interface fetch_decode_if;
  logic [7:0] imem_addr;
  logic [7:0] imem_instr;
  logic       dec_valid;
  logic       dec_ready;
  logic [2:0] dec_op;
  logic [1:0] dec_rd;
  logic [1:0] dec_rs;
  logic [7:0] dec_imm;
  logic [7:0] dec_pc;
  logic       redirect_valid;
  logic [7:0] redirect_pc;
  logic       halted;

  modport master (
    output imem_addr, dec_valid, dec_op, dec_rd, dec_rs, dec_imm, dec_pc, halted,
    input  imem_instr, dec_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_addr, dec_valid, dec_op, dec_rd, dec_rs, dec_imm, dec_pc, halted,
    output imem_instr, dec_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/instr_decode.sv
// Purely combinational field extraction and classification of one instruction byte.
module instr_decode
  import cpu_pkg::*;
(
  input  logic [7:0] instr,
  output logic [2:0] op,
  output logic [1:0] rd,
  output logic [1:0] rs,
  output logic       is_movi,
  output logic       is_nop,
  output logic       is_halt
);

  logic rsv_unused;

  assign rsv_unused = instr[RSV_BIT];

  // Split the byte into fields and flag the opcodes that steer the fetch FSM.
  always_comb begin
    op      = instr[OP_MSB:OP_LSB];
    rd      = instr[RD_MSB:RD_LSB];
    rs      = instr[RS_MSB:RS_LSB];
    is_movi = (instr[OP_MSB:OP_LSB] == OP_MOVI);
    is_nop  = (instr[OP_MSB:OP_LSB] == OP_NOP);
    is_halt = (instr == HALT_BYTE);
  end

endmodule

// File: rtl/fetch_decode.sv
// Fetch/decode stage: walks the PC, splits MOVI into opcode + immediate bytes and
// holds each decoded instruction until the consumer takes it. Define FETCH_HALT_EN to make 8'hFF halt.
module fetch_decode
  import cpu_pkg::*;
#(
  parameter logic [7:0] RESET_PC = 8'h00
)(
  input  logic           clk,
  input  logic           rst,
  fetch_decode_if.master bus
);

  state_e     state_q, state_d, state_n_s;
  logic [7:0] pc_q, pc_d, pc_n_s, pc_inc_s;
  logic [2:0] op_q, op_d;
  logic [1:0] rd_q, rd_d, rs_q, rs_d;
  logic [7:0] imm_q, imm_d, dpc_q, dpc_d;
  logic       valid_q, valid_d;
  logic       halted_q, halted_d, halted_n_s;
  logic [2:0] f_op_s;
  logic [1:0] f_rd_s, f_rs_s;
  logic       f_movi_s, f_nop_s, f_halt_s, halt_req_s, xfer_s;

  instr_decode u_decode (
    .instr   (bus.imem_instr),
    .op      (f_op_s),
    .rd      (f_rd_s),
    .rs      (f_rs_s),
    .is_movi (f_movi_s),
    .is_nop  (f_nop_s),
    .is_halt (f_halt_s)
  );

`ifdef FETCH_HALT_EN
  assign halt_req_s = f_halt_s;
  assign bus.halted = halted_q;
`else
  logic halt_unused;
  assign halt_req_s  = 1'b0;
  assign bus.halted  = 1'b0;
  assign halt_unused = f_halt_s ^ halted_q;
`endif

  assign pc_inc_s = pc_q + 8'd1;
  assign xfer_s   = valid_q && bus.dec_ready;

  // Next state of the fetch FSM and the decode latches, ignoring redirects.
  always_comb begin
    state_n_s  = state_q;
    pc_n_s     = pc_q;
    op_d       = op_q;
    rd_d       = rd_q;
    rs_d       = rs_q;
    imm_d      = imm_q;
    dpc_d      = dpc_q;
    halted_n_s = halted_q;
    case (state_q)
      S_FETCH: begin
        if (halt_req_s) begin
          state_n_s  = S_HALT;
          halted_n_s = 1'b1;
        end else if (f_nop_s) begin
          pc_n_s = pc_inc_s;
        end else begin
          op_d   = f_op_s;
          rd_d   = f_rd_s;
          rs_d   = f_rs_s;
          dpc_d  = pc_q;
          pc_n_s = pc_inc_s;
          if (f_movi_s) begin
            state_n_s = S_IMM;
          end else begin
            imm_d     = 8'h00;
            state_n_s = S_HOLD;
          end
        end
      end
      S_IMM: begin
        imm_d     = bus.imem_instr;
        pc_n_s    = pc_inc_s;
        state_n_s = S_HOLD;
      end
      S_HOLD: begin
        if (xfer_s) begin
          state_n_s = S_FETCH;
        end else begin
          state_n_s = S_HOLD;
        end
      end
      S_HALT:  state_n_s = S_HALT;
      default: state_n_s = S_FETCH;
    endcase
  end

  // A redirect overrides whatever the FSM decided; the held instruction is
  // still handed over on this edge if the consumer is taking it.
  assign state_d  = bus.redirect_valid ? S_FETCH         : state_n_s;
  assign pc_d     = bus.redirect_valid ? bus.redirect_pc : pc_n_s;
  assign halted_d = bus.redirect_valid ? 1'b0            : halted_n_s;
  assign valid_d  = (state_d == S_HOLD);

  // State and output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_FETCH;
      pc_q     <= RESET_PC;
      op_q     <= 3'd0;
      rd_q     <= 2'd0;
      rs_q     <= 2'd0;
      imm_q    <= 8'h00;
      dpc_q    <= RESET_PC;
      valid_q  <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      rs_q     <= rs_d;
      imm_q    <= imm_d;
      dpc_q    <= dpc_d;
      valid_q  <= valid_d;
      halted_q <= halted_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.dec_valid = valid_q;
  assign bus.dec_op    = op_q;
  assign bus.dec_rd    = rd_q;
  assign bus.dec_rs    = rs_q;
  assign bus.dec_imm   = imm_q;
  assign bus.dec_pc    = dpc_q;

endmodule

// File: tb/tb_fetch_decode.sv
// Scoreboard bench for fetch_decode: a program-walking reference model predicts the
// stream of decoded instructions, a negedge monitor compares every handshake transfer.
module tb_fetch_decode;

  typedef struct {
    logic [2:0] op;
    logic [1:0] rd;
    logic [1:0] rs;
    logic [7:0] imm;
    logic [7:0] pc;
  } exp_t;

`ifdef FETCH_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  mem [256];
  exp_t        exp_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  logic        have_snap = 1'b0;
  logic [30:0] snap = '0;
  logic [30:0] cur;

  fetch_decode_if bus ();

  fetch_decode #(.RESET_PC(8'h00)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  assign bus.imem_instr = mem[bus.imem_addr];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Reference model: interpret memory as a program from 'start' and queue the next n issued instructions.
  task automatic push_walk(input logic [7:0] start, input int n);
    logic [7:0] p;
    int         b;
    int         left;
    exp_t       e;
    p    = start;
    left = n;
    for (int guard = 0; guard < 512 && left > 0; guard++) begin
      b = int'(mem[p]);
      if (b / 32 == 7) begin
        if (HALT_EN && b == 255) break;
        p = p + 8'd1;
      end else begin
        e.op = 3'(b / 32);
        e.rd = 2'((b / 8) % 4);
        e.rs = 2'((b / 2) % 4);
        e.pc = p;
        if (b / 32 == 4) begin
          e.imm = mem[8'(p + 8'd1)];
          p = p + 8'd2;
        end else begin
          e.imm = 8'h00;
          p = p + 8'd1;
        end
        exp_q.push_back(e);
        left--;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive dec_ready until every expected transfer is consumed; optionally redirect once at cycle redir_at.
  task automatic run_stream(input int budget, input bit rnd, input int redir_at);
    for (int i = 0; i < budget; i++) begin
      if (i == redir_at) begin
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = 8'($urandom);
        bus.dec_ready      = ($urandom_range(0, 1) == 1);
        step();
        bus.redirect_valid = 1'b0;
        push_walk(bus.redirect_pc, 12);
      end
      if (exp_q.size() == 0) begin
        bus.dec_ready = 1'b0;
        return;
      end
      bus.dec_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      step();
    end
    bus.dec_ready = 1'b0;
    vectors++;
    miscompares++;
    $display("FAIL stream_timeout: %0d expected transfers outstanding, required 0", exp_q.size());
    exp_q.delete();
  endtask

  // Monitor: compare each transfer with the scoreboard and check hold stability.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      cur = {bus.dec_op, bus.dec_rd, bus.dec_rs, bus.dec_imm, bus.dec_pc, bus.imem_addr};
      if (rst) begin
        exp_q.delete();
        have_snap = 1'b0;
      end else begin
`ifndef FETCH_HALT_EN
        chk("halted_tied", 32'(bus.halted), 32'd0);
`endif
        if (have_snap) begin
          chk("hold_valid", 32'(bus.dec_valid), 32'd1);
          chk("hold_stable", 32'(cur), 32'(snap));
        end
        if (bus.dec_valid && bus.dec_ready) begin
          if (exp_q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL unexpected_xfer: transfer of pc %0h, required no transfer", bus.dec_pc);
          end else begin
            e = exp_q.pop_front();
            chk("xfer_op", 32'(bus.dec_op), 32'(e.op));
            chk("xfer_rd", 32'(bus.dec_rd), 32'(e.rd));
            chk("xfer_rs", 32'(bus.dec_rs), 32'(e.rs));
            chk("xfer_imm", 32'(bus.dec_imm), 32'(e.imm));
            chk("xfer_pc", 32'(bus.dec_pc), 32'(e.pc));
          end
        end
        have_snap = bus.dec_valid && !bus.dec_ready && !bus.redirect_valid;
        snap      = cur;
        if (bus.redirect_valid) exp_q.delete();
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] b;
    bus.dec_ready      = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 8'h00;
    for (int a = 0; a < 256; a++) mem[a] = 8'hE0;
    mem[0] = 8'h08; mem[1] = 8'h32; mem[2] = 8'hE0; mem[3] = 8'hFF;
    mem[4] = 8'h88; mem[5] = 8'h5A; mem[6] = 8'h4C;

    // Reset values.
    rst = 1'b1;
    step();
    chk("reset_addr", 32'(bus.imem_addr), 32'h00);
    chk("reset_valid", 32'(bus.dec_valid), 32'd0);
    chk("reset_halted", 32'(bus.halted), 32'd0);
    chk("reset_dec_pc", 32'(bus.dec_pc), 32'h00);
    chk("reset_imm", 32'(bus.dec_imm), 32'h00);
    chk("reset_op", 32'({bus.dec_op, bus.dec_rd, bus.dec_rs}), 32'd0);
    rst = 1'b0;
    push_walk(8'h00, 4);
    bus.dec_ready = 1'b1;

    // ADD R1,R0 issues one cycle after fetch.
    step();
    chk("add_valid", 32'(bus.dec_valid), 32'd1);
    chk("add_fields", 32'({bus.dec_op, bus.dec_rd, bus.dec_rs}), 32'({3'd0, 2'd1, 2'd0}));
    chk("add_pc", 32'(bus.dec_pc), 32'h00);
    chk("add_addr", 32'(bus.imem_addr), 32'h01);
    step();
    chk("post_xfer_valid", 32'(bus.dec_valid), 32'd0);
    chk("post_xfer_addr", 32'(bus.imem_addr), 32'h01);
    bus.dec_ready = 1'b0;

    // SUB held for three cycles of back-pressure.
    step();
    chk("sub_valid", 32'(bus.dec_valid), 32'd1);
    chk("sub_fields", 32'({bus.dec_op, bus.dec_rd, bus.dec_rs}), 32'({3'd1, 2'd2, 2'd1}));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_addr", 32'(bus.imem_addr), 32'h02);
      chk("stall_pc", 32'(bus.dec_pc), 32'h01);
    end
    bus.dec_ready = 1'b1;
    step();
    chk("sub_taken_valid", 32'(bus.dec_valid), 32'd0);
    chk("sub_taken_addr", 32'(bus.imem_addr), 32'h02);
    step();
    chk("nop_addr", 32'(bus.imem_addr), 32'h03);
    chk("nop_valid", 32'(bus.dec_valid), 32'd0);
    step();
`ifdef FETCH_HALT_EN
    chk("halt_flag", 32'(bus.halted), 32'd1);
    chk("halt_addr", 32'(bus.imem_addr), 32'h03);
    step();
    step();
    chk("halt_hold_addr", 32'(bus.imem_addr), 32'h03);
    chk("halt_hold_valid", 32'(bus.dec_valid), 32'd0);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h04;
    step();
    bus.redirect_valid = 1'b0;
    push_walk(8'h04, 2);
    chk("unhalt_flag", 32'(bus.halted), 32'd0);
    chk("unhalt_addr", 32'(bus.imem_addr), 32'h04);
`else
    chk("ff_nop_addr", 32'(bus.imem_addr), 32'h04);
    chk("ff_nop_valid", 32'(bus.dec_valid), 32'd0);
`endif

    // MOVI R1,#5A issues two cycles after its opcode fetch.
    step();
    chk("movi_mid_valid", 32'(bus.dec_valid), 32'd0);
    chk("movi_mid_addr", 32'(bus.imem_addr), 32'h05);
    step();
    chk("movi_valid", 32'(bus.dec_valid), 32'd1);
    chk("movi_fields", 32'({bus.dec_op, bus.dec_rd, bus.dec_imm, bus.dec_pc}), 32'({3'd4, 2'd1, 8'h5A, 8'h04}));
    chk("movi_next_addr", 32'(bus.imem_addr), 32'h06);
    run_stream(100, 1'b0, -1);

    // Reset in the middle of a MOVI, then redirect during IMM.
    mem[0] = 8'h90; mem[1] = 8'h11; mem[8'h40] = 8'h2A; mem[8'h41] = 8'hE0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    chk("imm_state_addr", 32'(bus.imem_addr), 32'h01);
    rst = 1'b1;
    #1;
    chk("mid_rst_addr", 32'(bus.imem_addr), 32'h00);
    chk("mid_rst_valid", 32'(bus.dec_valid), 32'd0);
    step();
    rst = 1'b0;
    step();
    chk("refetch_addr", 32'(bus.imem_addr), 32'h01);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'h40;
    bus.dec_ready      = 1'b1;
    step();
    bus.redirect_valid = 1'b0;
    push_walk(8'h40, 1);
    chk("redir_valid", 32'(bus.dec_valid), 32'd0);
    chk("redir_addr", 32'(bus.imem_addr), 32'h40);
    step();
    chk("redir_op", 32'(bus.dec_op), 32'd1);
    chk("redir_pc", 32'(bus.dec_pc), 32'h40);
    run_stream(50, 1'b0, -1);

    // MOVI at FF takes its immediate from address 00.
    mem[8'hFF] = 8'h98; mem[0] = 8'h77;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 8'hFF;
    step();
    bus.redirect_valid = 1'b0;
    push_walk(8'hFF, 1);
    step();
    step();
    chk("wrap_valid", 32'(bus.dec_valid), 32'd1);
    chk("wrap_imm", 32'(bus.dec_imm), 32'h77);
    chk("wrap_pc", 32'(bus.dec_pc), 32'hFF);
    chk("wrap_addr", 32'(bus.imem_addr), 32'h01);
    run_stream(20, 1'b0, -1);

    // Random programs with random back-pressure and one random redirect each.
    for (int ph = 0; ph < 6; ph++) begin
      for (int a = 0; a < 256; a++) begin
        b = 8'($urandom);
        if (b == 8'hFF) b = 8'h08;
        mem[a] = b;
      end
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      push_walk(8'h00, 24);
      run_stream(800, 1'b1, int'($urandom_range(4, 40)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/fetch_decode.md
FETCH_DECODE -- requirements
Module: fetch_decode

Interface
REQ-001 SHALL have parameter RESET_PC, default 8'h00: fetch address loaded on reset.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port imem_addr  output  8  instruction-memory address (equals internal PC).
REQ-005 SHALL have port imem_instr  input  8  instruction byte, combinationally valid in the same cycle as imem_addr.
REQ-006 SHALL have port dec_valid  output  1  decoded instruction available.
REQ-007 SHALL have port dec_ready  input  1  consumer accepts; a transfer occurs when dec_valid and dec_ready are both high on a rising edge.
REQ-008 SHALL have ports dec_op (output, 3), dec_rd (output, 2), dec_rs (output, 2), dec_imm (output, 8), dec_pc (output, 8): opcode, destination, source, immediate, and instruction address.
REQ-009 SHALL have ports redirect_valid (input, 1) and redirect_pc (input, 8): PC override from execute.
REQ-010 SHALL have port halted  output  1  fetch stopped.

Function
REQ-011 SHALL decode each instruction byte as opcode=[7:5], rd=[4:3], rs=[2:1]; bit 0 is reserved and ignored.
REQ-012 SHALL implement states FETCH, IMM, HOLD and HALT.
REQ-013 In FETCH with opcode 100 (MOVI), SHALL latch op/rd/rs/pc, set PC to PC+1 and go to IMM.
REQ-014 In FETCH with opcode 111 (NOP), SHALL set PC to PC+1, stay in FETCH and never assert dec_valid.
REQ-015 In FETCH with any other opcode, SHALL latch the fields, set dec_imm to 8'h00, set PC to PC+1 and go to HOLD.
REQ-016 In IMM, SHALL latch imem_instr into dec_imm, set PC to PC+1 and go to HOLD.
REQ-017 dec_valid SHALL be high exactly while in HOLD, and the dec_* outputs SHALL remain stable until the transfer occurs.
REQ-018 In HOLD, SHALL go to FETCH on transfer; otherwise SHALL stay in HOLD with PC frozen.
REQ-019 Latency SHALL be: non-MOVI valid 1 cycle after fetch; MOVI valid 2 cycles after fetch of the opcode byte.
REQ-020 PC SHALL wrap 8'hFF to 8'h00; a MOVI at 8'hFF SHALL take its immediate from 8'h00.
REQ-021 redirect_valid SHALL have priority over every state, including HALT: PC<=redirect_pc, state<=FETCH, dec_valid low the next cycle, halted cleared, and any pending instruction or immediate discarded.
REQ-022 A redirect coincident with a transfer SHALL complete the transfer and then apply the redirect.

Reset
REQ-023 On rst: PC=RESET_PC, state=FETCH, dec_valid=0, dec_op/rd/rs=0, dec_imm=8'h00, dec_pc=RESET_PC, halted=0.
REQ-024 Reset asserted mid-MOVI or in HOLD SHALL abandon the instruction; after release, the first fetch SHALL be from RESET_PC.

Configuration
REQ-025 With macro FETCH_HALT_EN defined, byte 8'hFF in FETCH SHALL enter HALT: halted=1, PC frozen, no issue, until reset or redirect.
REQ-026 Without FETCH_HALT_EN, 8'hFF SHALL be treated as a NOP and halted SHALL be tied to 0.

Structure
REQ-027 Opcode constants (ADD=000, SUB=001, AND=010, OR=011, MOVI=100, NOP=111), the state encoding and the field bit positions SHALL live in the shared package cpu_pkg.
REQ-028 Field extraction SHALL be one combinational sub-module, instr_decode (byte in -> op/rd/rs, is_movi, is_nop, is_halt).

Verification
REQ-029 rst pulse -> imem_addr=8'h00, dec_valid=0, halted=0.
REQ-030 mem[0]=8'h08 (ADD R1,R0), dec_ready=1 -> next cycle dec_valid=1, dec_op=0, dec_rd=1, dec_rs=0, dec_pc=0, imem_addr=1.
REQ-031 mem[4]=8'h88, mem[5]=8'h5A -> dec_op=4, dec_rd=1, dec_imm=8'h5A, dec_pc=4; next fetch from 6.
REQ-032 dec_ready=0 for 3 cycles in HOLD -> dec_* outputs stable and imem_addr unchanged; transfer occurs on the cycle dec_ready rises.
REQ-033 redirect_valid=1, redirect_pc=8'h40 during IMM -> dec_valid=0 next cycle, imem_addr=8'h40, MOVI discarded.
REQ-034 mem[2]=8'hE0 -> no dec_valid for it, and address 3 fetched next; with FETCH_HALT_EN, mem[3]=8'hFF -> halted=1 and imem_addr held at 3.
